data_mem: RTL and testbench
===========================

# data_mem

Data-memory responder for the CPU's RAM port, attached to the CPU's `o_ram_*` outputs and returning read data on `i_ram_data`. It stores the data space and serves CPU reads after a fixed, parameterised latency, with a valid strobe on each response. Writes complete in one cycle. A small memory-mapped I/O window at the top of the address space holds an output port, a cycle counter and a write counter.

## Interface
Parameters:
- g_RAM_WIDTH, 9, data word width (bits).
- g_RAM_ADDR, 11, address width; the array holds 2^g_RAM_ADDR words.
- g_READ_LATENCY, 1, cycles from an accepted read to its response; legal range 1..4.
- g_IO_BASE, 2040, first address of the 8-word I/O window; must be a multiple of 8.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous reset, active-high.
- i_ram_en  in  1  port enable; no request is taken while low.
- i_ram_we  in  1  write request.
- i_ram_re  in  1  read request.
- i_ram_addr  in  g_RAM_ADDR  request address.
- i_ram_data  in  g_RAM_WIDTH  write data.
- o_ram_data  out  g_RAM_WIDTH  read response data.
- o_ram_valid  out  1  one-cycle strobe; o_ram_data is valid on this cycle.
- o_gpio  out  g_RAM_WIDTH  output port register.

## Operation
- **Request acceptance.** A request is accepted on a rising edge where i_ram_en=1 and (i_ram_we=1 or i_ram_re=1).
- **Simultaneous we and re.** The request is treated as a write only. No read response is produced.
- **Writes outside the I/O window.** The array word at i_ram_addr is updated at the accepting edge.
- **Reads.** Data is sampled at the accepting edge and enters a g_READ_LATENCY-deep valid/data shift pipeline.
  - Back-to-back reads issue one per cycle.
  - Responses return in request order with no gaps.
- **o_ram_data** holds the last response until the next o_ram_valid pulse.
- **I/O window** covers g_IO_BASE .. g_IO_BASE+7. Accesses here never touch the array.
  - Offset 0: o_gpio register, read/write.
  - Offset 1: cycle counter bits [g_RAM_WIDTH-1:0]. A write of any value clears the counter.
  - Offset 2: cycle counter bits [2*g_RAM_WIDTH-1:g_RAM_WIDTH], read-only.
  - Offset 3: write counter, read-only.
  - Offsets 4-7: read 0; writes ignored.
- **Cycle counter.** 2*g_RAM_WIDTH bits wide. Increments every cycle out of reset and wraps to 0.
  - A clearing write loads 0 at its edge; the counter then increments normally.
- **Write counter.** Incremented by every accepted write at any address, including I/O writes. Saturates at all-ones.
- **Read-after-write.** A read accepted the cycle after a write to the same address returns the new value.
- **Address range.** Addresses wrap naturally within g_RAM_ADDR bits; there are no out-of-range errors.

## Timing
- **Reset values.** o_ram_data=0, o_ram_valid=0, o_gpio=0; pipeline valids cleared; both counters 0.
- **Array contents** are not cleared by reset.
- **Read latency.** A read accepted at edge N produces o_ram_valid=1 in the cycle following edge N+g_READ_LATENCY-1.
  - With g_READ_LATENCY=1, the data is visible right after the accepting edge.
- **Write timing.** Zero wait states; the updated value is readable at the next edge.
- **I/O read sampling.** I/O reads return the register value before any update at the same edge. A read of offset 1 returns the pre-increment counter.
- **Reset mid-operation.** In-flight reads are discarded. No o_ram_valid is produced for them after reset is released.
- **While i_ram_en=0.** Requests are ignored. The pipeline drains and the counters keep running.

## Configuration
- Macro: DATA_MEM_IO_EN.
- **Defined:** the I/O window, o_gpio and both counters are implemented as described.
- **Undefined:** the whole address space is plain RAM, including g_IO_BASE..+7. o_gpio is tied to 0 and the counters are not built.

## Test plan
- **Reset.** Assert i_rst mid-stream with 2 reads in flight (g_READ_LATENCY=3) -> o_ram_valid=0, o_ram_data=0, o_gpio=0 immediately; no valid pulse after release.
- **Streaming reads.** Write 0x1A5 to addr 5, then read addr 5, 6, 5 back-to-back at latency 2 -> three consecutive valid pulses carrying 0x1A5, old[6], 0x1A5.
- **Read-after-write.** Write 0x0F0 to addr 12 at edge N and read addr 12 at edge N+1 -> response 0x0F0.
- **Simultaneous we+re.** Assert both with addr 7, data 0x003 -> array[7]=0x003, no o_ram_valid pulse.
- **I/O window (macro defined).** Write 0x155 to 2040 -> o_gpio=0x155 next cycle. Write 2041, idle 10 cycles, then read 2041 -> 10. After 600 writes, offset 3 reads 511.
- **I/O window (macro undefined).** Write 0x155 to 2040 -> o_gpio stays 0; read 2040 returns 0x155.

Source files
------------

// File: rtl/data_mem.sv
// ============================================================================
//  Module   : data_mem
//  Purpose  : Data-memory responder for the CPU RAM port. Serves reads after
//             g_READ_LATENCY cycles with a valid strobe, completes writes in
//             one cycle. Define DATA_MEM_IO_EN to build the 8-word I/O window
//             (gpio register, cycle counter, write counter) at g_IO_BASE.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem #(
  parameter int g_RAM_WIDTH    = 9,
  parameter int g_RAM_ADDR     = 11,
  parameter int g_READ_LATENCY = 1,
  parameter int g_IO_BASE      = 2040
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_ram_en,
  input  logic                   i_ram_we,
  input  logic                   i_ram_re,
  input  logic [g_RAM_ADDR-1:0]  i_ram_addr,
  input  logic [g_RAM_WIDTH-1:0] i_ram_data,
  output logic [g_RAM_WIDTH-1:0] o_ram_data,
  output logic                   o_ram_valid,
  output logic [g_RAM_WIDTH-1:0] o_gpio
);

  localparam int c_DEPTH = 2 ** g_RAM_ADDR;

  // Reject parameter sets the pipeline or the window decode cannot honour.
  if ((g_READ_LATENCY < 1) || (g_READ_LATENCY > 4) || ((g_IO_BASE % 8) != 0)) begin : g_cfg_err
    $error("data_mem: illegal parameter set");
  end

  logic [g_RAM_WIDTH-1:0] r_mem [c_DEPTH];

  // Simultaneous we+re is a plain write: the read qualifier masks it out.
  logic w_wr;
  logic w_rd;
  logic w_mem_we;
  logic [g_RAM_WIDTH-1:0] w_rd_data;

  assign w_wr = i_ram_en & i_ram_we;
  assign w_rd = i_ram_en & i_ram_re & ~i_ram_we;

`ifdef DATA_MEM_IO_EN
  localparam logic [g_RAM_ADDR-4:0]    c_IO_PAGE  = (g_RAM_ADDR-3)'(g_IO_BASE / 8);
  localparam logic [2*g_RAM_WIDTH-1:0] c_CYC_ONE  = 1;
  localparam logic [g_RAM_WIDTH-1:0]   c_WCNT_ONE = 1;
  localparam logic [g_RAM_WIDTH-1:0]   c_WCNT_MAX = '1;

  logic                     w_io_hit;
  logic [2:0]               w_io_off;
  logic [g_RAM_WIDTH-1:0]   w_io_rdata;
  logic [g_RAM_WIDTH-1:0]   r_gpio;
  logic [2*g_RAM_WIDTH-1:0] r_cyc;
  logic [g_RAM_WIDTH-1:0]   r_wcnt;

  assign w_io_hit = (i_ram_addr[g_RAM_ADDR-1:3] == c_IO_PAGE);
  assign w_io_off = i_ram_addr[2:0];

  // I/O read mux sees register values before this edge's update.
  always_comb begin
    w_io_rdata = '0;
    case (w_io_off)
      3'd0:    w_io_rdata = r_gpio;
      3'd1:    w_io_rdata = r_cyc[g_RAM_WIDTH-1:0];
      3'd2:    w_io_rdata = r_cyc[2*g_RAM_WIDTH-1:g_RAM_WIDTH];
      3'd3:    w_io_rdata = r_wcnt;
      default: w_io_rdata = '0;
    endcase
  end

  assign w_mem_we  = w_wr & ~w_io_hit;
  assign w_rd_data = w_io_hit ? w_io_rdata : r_mem[i_ram_addr];
  assign o_gpio    = r_gpio;

  // I/O registers: gpio, free-running cycle counter, saturating write counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_gpio <= '0;
      r_cyc  <= '0;
      r_wcnt <= '0;
    end else begin
      if (w_wr && w_io_hit && (w_io_off == 3'd1)) begin
        r_cyc <= '0;
      end else begin
        r_cyc <= r_cyc + c_CYC_ONE;
      end
      if (w_wr && w_io_hit && (w_io_off == 3'd0)) begin
        r_gpio <= i_ram_data;
      end
      if (w_wr && (r_wcnt != c_WCNT_MAX)) begin
        r_wcnt <= r_wcnt + c_WCNT_ONE;
      end
    end
  end
`else
  assign w_mem_we  = w_wr;
  assign w_rd_data = r_mem[i_ram_addr];
  assign o_gpio    = '0;
`endif

  // Array write port; contents deliberately survive reset.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[i_ram_addr] <= i_ram_data;
    end
  end

  logic [g_READ_LATENCY-1:0] r_vld;
  logic [g_RAM_WIDTH-1:0]    r_dat [g_READ_LATENCY];

  // Read pipeline: data only moves with a valid, so the last stage holds
  // the most recent response between strobes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < g_READ_LATENCY; i++) begin
        r_vld[i] <= 1'b0;
        r_dat[i] <= '0;
      end
    end else begin
      r_vld[0] <= w_rd;
      if (w_rd) begin
        r_dat[0] <= w_rd_data;
      end
      for (int i = 1; i < g_READ_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) begin
          r_dat[i] <= r_dat[i-1];
        end
      end
    end
  end

  assign o_ram_valid = r_vld[g_READ_LATENCY-1];
  assign o_ram_data  = r_dat[g_READ_LATENCY-1];

endmodule

`default_nettype wire

// File: tb/tb_data_mem.sv
// ============================================================================
//  Module   : tb_data_mem
//  Purpose  : Directed self-checking bench for data_mem. Two instances share
//             stimulus: latency 2 for the main scenarios, latency 3 for the
//             mid-stream reset scenario. Honours DATA_MEM_IO_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem;

  logic        clk;
  logic        rst;
  logic        en;
  logic        we;
  logic        re;
  logic [10:0] addr;
  logic [8:0]  wdata;
  logic [8:0]  rdata2;
  logic        valid2;
  logic [8:0]  gpio2;
  logic [8:0]  rdata3;
  logic        valid3;
  logic [8:0]  gpio3;

  int nchecks;
  int nerrors;

  data_mem #(.g_RAM_WIDTH(9), .g_RAM_ADDR(11), .g_READ_LATENCY(2), .g_IO_BASE(2040)) u_dut_l2 (
    .i_clk(clk), .i_rst(rst), .i_ram_en(en), .i_ram_we(we), .i_ram_re(re),
    .i_ram_addr(addr), .i_ram_data(wdata),
    .o_ram_data(rdata2), .o_ram_valid(valid2), .o_gpio(gpio2)
  );

  data_mem #(.g_RAM_WIDTH(9), .g_RAM_ADDR(11), .g_READ_LATENCY(3), .g_IO_BASE(2040)) u_dut_l3 (
    .i_clk(clk), .i_rst(rst), .i_ram_en(en), .i_ram_we(we), .i_ram_re(re),
    .i_ram_addr(addr), .i_ram_data(wdata),
    .o_ram_data(rdata3), .o_ram_valid(valid3), .o_gpio(gpio3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic w, input logic r,
                       input logic [10:0] a, input logic [8:0] d);
    en = e; we = w; re = r; addr = a; wdata = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 11'd0, 9'd0);
  endtask

  task automatic wr(input logic [10:0] a, input logic [8:0] d);
    drive(1'b1, 1'b1, 1'b0, a, d);
    step();
    idle();
  endtask

  // Single read on the latency-2 instance; returns what appears two edges later.
  task automatic rd2(input logic [10:0] a, output logic v, output logic [8:0] d);
    drive(1'b1, 1'b0, 1'b1, a, 9'd0);
    step();
    idle();
    step();
    v = valid2;
    d = rdata2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    nchecks++;
    if (valid2 !== 1'b0 || rdata2 !== 9'd0 || gpio2 !== 9'd0) begin
      nerrors++;
      $display("FAIL reset_l2: valid=%b data=%h gpio=%h, required 0/000/000", valid2, rdata2, gpio2);
    end
    nchecks++;
    if (valid3 !== 1'b0 || rdata3 !== 9'd0 || gpio3 !== 9'd0) begin
      nerrors++;
      $display("FAIL reset_l3: valid=%b data=%h gpio=%h, required 0/000/000", valid3, rdata3, gpio3);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_streaming();
    wr(11'd5, 9'h1A5);
    wr(11'd6, 9'h0AA);
    drive(1'b1, 1'b0, 1'b1, 11'd5, 9'd0);
    step();
    nchecks++;
    if (valid2 !== 1'b0) begin
      nerrors++;
      $display("FAIL stream_early: valid=%b, required 0", valid2);
    end
    drive(1'b1, 1'b0, 1'b1, 11'd6, 9'd0);
    step();
    nchecks++;
    if (valid2 !== 1'b1 || rdata2 !== 9'h1A5) begin
      nerrors++;
      $display("FAIL stream_rsp0: valid=%b data=%h, required 1/1a5", valid2, rdata2);
    end
    drive(1'b1, 1'b0, 1'b1, 11'd5, 9'd0);
    step();
    nchecks++;
    if (valid2 !== 1'b1 || rdata2 !== 9'h0AA) begin
      nerrors++;
      $display("FAIL stream_rsp1: valid=%b data=%h, required 1/0aa", valid2, rdata2);
    end
    idle();
    step();
    nchecks++;
    if (valid2 !== 1'b1 || rdata2 !== 9'h1A5) begin
      nerrors++;
      $display("FAIL stream_rsp2: valid=%b data=%h, required 1/1a5", valid2, rdata2);
    end
    step();
    nchecks++;
    if (valid2 !== 1'b0 || rdata2 !== 9'h1A5) begin
      nerrors++;
      $display("FAIL stream_hold: valid=%b data=%h, required 0/1a5", valid2, rdata2);
    end
  endtask

  task automatic test_read_after_write();
    wr(11'd12, 9'h111);
    drive(1'b1, 1'b1, 1'b0, 11'd12, 9'h0F0);
    step();
    drive(1'b1, 1'b0, 1'b1, 11'd12, 9'd0);
    step();
    idle();
    step();
    nchecks++;
    if (valid2 !== 1'b1 || rdata2 !== 9'h0F0) begin
      nerrors++;
      $display("FAIL raw: valid=%b data=%h, required 1/0f0", valid2, rdata2);
    end
  endtask

  task automatic test_we_re();
    logic       v;
    logic [8:0] d;
    int         seen;
    wr(11'd7, 9'h1FF);
    step();
    step();
    drive(1'b1, 1'b1, 1'b1, 11'd7, 9'h003);
    step();
    idle();
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (valid2 === 1'b1 || valid3 === 1'b1) seen++;
      step();
    end
    nchecks++;
    if (seen != 0) begin
      nerrors++;
      $display("FAIL we_re_novalid: valid pulses=%0d, required 0", seen);
    end
    rd2(11'd7, v, d);
    nchecks++;
    if (v !== 1'b1 || d !== 9'h003) begin
      nerrors++;
      $display("FAIL we_re_data: valid=%b data=%h, required 1/003", v, d);
    end
  endtask

  task automatic test_addr_wrap();
    logic       v;
    logic [8:0] d;
    wr(11'd0, 9'h0C3);
    wr(11'd1, 9'h13C);
    rd2(11'd0, v, d);
    nchecks++;
    if (v !== 1'b1 || d !== 9'h0C3) begin
      nerrors++;
      $display("FAIL addr0: valid=%b data=%h, required 1/0c3", v, d);
    end
    rd2(11'd1, v, d);
    nchecks++;
    if (v !== 1'b1 || d !== 9'h13C) begin
      nerrors++;
      $display("FAIL addr1: valid=%b data=%h, required 1/13c", v, d);
    end
  endtask

`ifdef DATA_MEM_IO_EN
  task automatic test_io_window();
    logic       v;
    logic [8:0] d;
    wr(11'd2040, 9'h155);
    nchecks++;
    if (gpio2 !== 9'h155) begin
      nerrors++;
      $display("FAIL gpio_write: gpio=%h, required 155", gpio2);
    end
    rd2(11'd2040, v, d);
    nchecks++;
    if (v !== 1'b1 || d !== 9'h155) begin
      nerrors++;
      $display("FAIL gpio_read: valid=%b data=%h, required 1/155", v, d);
    end
    drive(1'b1, 1'b1, 1'b0, 11'd2041, 9'h1EE);
    step();
    idle();
    repeat (10) step();
    rd2(11'd2041, v, d);
    nchecks++;
    if (v !== 1'b1 || d !== 9'd10) begin
      nerrors++;
      $display("FAIL cyc_lo: valid=%b data=%0d, required 1/10", v, d);
    end
    rd2(11'd2042, v, d);
    nchecks++;
    if (v !== 1'b1 || d !== 9'd0) begin
      nerrors++;
      $display("FAIL cyc_hi: valid=%b data=%0d, required 1/0", v, d);
    end
    wr(11'd2044, 9'h1FF);
    rd2(11'd2044, v, d);
    nchecks++;
    if (v !== 1'b1 || d !== 9'd0) begin
      nerrors++;
      $display("FAIL io_off4: valid=%b data=%h, required 1/000", v, d);
    end
    for (int i = 0; i < 600; i++) begin
      drive(1'b1, 1'b1, 1'b0, 11'd100, 9'(i));
      step();
    end
    idle();
    rd2(11'd2043, v, d);
    nchecks++;
    if (v !== 1'b1 || d !== 9'd511) begin
      nerrors++;
      $display("FAIL wcnt_sat: valid=%b data=%0d, required 1/511", v, d);
    end
  endtask
`else
  task automatic test_io_window();
    logic       v;
    logic [8:0] d;
    wr(11'd2040, 9'h155);
    nchecks++;
    if (gpio2 !== 9'h000) begin
      nerrors++;
      $display("FAIL gpio_tied: gpio=%h, required 000", gpio2);
    end
    rd2(11'd2040, v, d);
    nchecks++;
    if (v !== 1'b1 || d !== 9'h155) begin
      nerrors++;
      $display("FAIL plain_2040: valid=%b data=%h, required 1/155", v, d);
    end
    wr(11'd2043, 9'h0A5);
    rd2(11'd2043, v, d);
    nchecks++;
    if (v !== 1'b1 || d !== 9'h0A5) begin
      nerrors++;
      $display("FAIL plain_2043: valid=%b data=%h, required 1/0a5", v, d);
    end
  endtask
`endif

  task automatic test_reset_midstream();
    int seen;
    wr(11'd20, 9'h05A);
    wr(11'd21, 9'h0A5);
    step();
    step();
    step();
    drive(1'b1, 1'b0, 1'b1, 11'd20, 9'd0);
    step();
    drive(1'b1, 1'b0, 1'b1, 11'd21, 9'd0);
    step();
    idle();
    #2;
    rst = 1'b1;
    #1;
    nchecks++;
    if (valid3 !== 1'b0 || rdata3 !== 9'd0 || gpio3 !== 9'd0) begin
      nerrors++;
      $display("FAIL rst_mid_l3: valid=%b data=%h gpio=%h, required 0/000/000", valid3, rdata3, gpio3);
    end
    nchecks++;
    if (rdata2 !== 9'd0 || gpio2 !== 9'd0) begin
      nerrors++;
      $display("FAIL rst_mid_l2: data=%h gpio=%h, required 000/000", rdata2, gpio2);
    end
    step();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (valid3 === 1'b1 || valid2 === 1'b1) seen++;
    end
    nchecks++;
    if (seen != 0) begin
      nerrors++;
      $display("FAIL rst_no_pulse: valid pulses=%0d, required 0", seen);
    end
  endtask

  initial begin
    nchecks = 0;
    nerrors = 0;
    rst = 1'b0;
    idle();
    test_reset();
    test_streaming();
    test_read_after_write();
    test_we_re();
    test_addr_wrap();
    test_io_window();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

`default_nettype wire
